// File: rtl/memory_pkg.sv
// Shared Wishbone constants and default geometry for the memory slave.
package memory_pkg;
  localparam int   SEL_WIDTH   = 4;
  localparam logic WE_READ     = 1'b0;
  localparam logic WE_WRITE    = 1'b1;
  localparam int   DEF_DWIDTH  = 32;
  localparam int   DEF_AWIDTH  = 5;
endpackage

// File: rtl/memory_array.sv
// 2^AWIDTH x DWIDTH storage: per-lane write enables, async clear, registered read.
module memory_array
  import memory_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [AWIDTH-1:0]    addr,
  input  logic [DWIDTH-1:0]    wdata,
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [DWIDTH-1:0]    rdata
);
  localparam int DEPTH = 1 << AWIDTH;
  localparam int LW    = DWIDTH / SEL_WIDTH;

  logic [DEPTH-1:0][DWIDTH-1:0] mem;

  // Lane-masked write; the whole array clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (req && we == WE_WRITE) begin
      for (int i = 0; i < SEL_WIDTH; i++)
        if (sel[i]) mem[addr][i*LW +: LW] <= wdata[i*LW +: LW];
    end
  end

  // Full-word read; holds until the next accepted read (writes leave it alone).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            rdata <= '0;
    else if (req && we == WE_READ)      rdata <= mem[addr];
  end
endmodule

// File: rtl/memory.sv
// Wishbone B4 pipelined slave RAM; never stalls, acks one cycle after each request.
module memory
  import memory_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic                 m_clk,
  input  logic                 m_rst,
  input  logic                 m_i_cyc,
  input  logic                 m_i_stb,
  input  logic                 m_i_we,
  input  logic [AWIDTH-1:0]    m_i_addr,
  input  logic [DWIDTH-1:0]    m_i_data,
  input  logic [SEL_WIDTH-1:0] m_i_sel,
  output logic [DWIDTH-1:0]    m_o_read_data,
  output logic                 m_o_ack,
  output logic                 m_o_stall
);
  logic accept;

  // No back-pressure: the array accepts one access every clock.
  assign m_o_stall = 1'b0;
  // Dropping cyc kills the request, so an aborted cycle never gets an ack.
  assign accept    = m_i_cyc & m_i_stb & ~m_o_stall;

  // Single-stage ack pipeline; reset clears a pending ack immediately.
  always_ff @(posedge m_clk or posedge m_rst) begin
    if (m_rst) m_o_ack <= 1'b0;
    else       m_o_ack <= accept;
  end

  memory_array #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_array (
    .clk   (m_clk),
    .rst   (m_rst),
    .req   (accept),
    .we    (m_i_we),
    .addr  (m_i_addr),
    .wdata (m_i_data),
    .sel   (m_i_sel),
    .rdata (m_o_read_data)
  );
endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: vector table, random model phase, async reset sequence.
module tb_memory;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;

  logic          m_clk = 1'b0;
  logic          m_rst = 1'b1;
  logic          m_i_cyc = 1'b0, m_i_stb = 1'b0, m_i_we = 1'b0;
  logic [AW-1:0] m_i_addr = '0;
  logic [DW-1:0] m_i_data = '0;
  logic [3:0]    m_i_sel = '0;
  logic [DW-1:0] m_o_read_data;
  logic          m_o_ack, m_o_stall;

  memory #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .m_clk(m_clk), .m_rst(m_rst), .m_i_cyc(m_i_cyc), .m_i_stb(m_i_stb),
    .m_i_we(m_i_we), .m_i_addr(m_i_addr), .m_i_data(m_i_data), .m_i_sel(m_i_sel),
    .m_o_read_data(m_o_read_data), .m_o_ack(m_o_ack), .m_o_stall(m_o_stall)
  );

  always #5 m_clk = ~m_clk;

  typedef struct packed {
    logic          ack;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic          cyc, stb, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    sel;
    logic          eack;
    logic [DW-1:0] edata;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  // model state for the random phase
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_rd;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic add_vec(input logic cyc, stb, we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [3:0] sel,
                         input logic eack, input logic [DW-1:0] edata);
    vec_t v;
    v.cyc = cyc; v.stb = stb; v.we = we; v.addr = addr; v.data = data; v.sel = sel;
    v.eack = eack; v.edata = edata;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, queue its expectation, sample #1 after the edge.
  task automatic drive(input string name, input logic cyc, stb, we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [3:0] sel, input logic eack, input logic [DW-1:0] edata);
    exp_t e;
    m_i_cyc = cyc; m_i_stb = stb; m_i_we = we;
    m_i_addr = addr; m_i_data = data; m_i_sel = sel;
    sb.push_back('{ack: eack, data: edata});
    @(posedge m_clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      chk({name, ".ack"},   {{(DW-1){1'b0}}, m_o_ack}, {{(DW-1){1'b0}}, e.ack});
      chk({name, ".data"},  m_o_read_data, e.data);
      chk({name, ".stall"}, {{(DW-1){1'b0}}, m_o_stall}, '0);
    end
  endtask

  initial begin
    logic c, s, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0] sl;

    // reset, then idle
    #2;
    chk("rst.ack",   {{(DW-1){1'b0}}, m_o_ack}, '0);
    chk("rst.data",  m_o_read_data, '0);
    chk("rst.stall", {{(DW-1){1'b0}}, m_o_stall}, '0);
    @(negedge m_clk);
    @(negedge m_clk);
    m_rst = 1'b0;
    @(posedge m_clk); #1;

    //       cyc stb we addr data          sel      ack data
    add_vec(0, 0, 0, 0,  32'h0,          4'h0,    0, 32'h0);
    add_vec(1, 1, 0, 0,  32'h0,          4'h0,    1, 32'h0);
    add_vec(1, 1, 0, 0,  32'h0,          4'h0,    1, 32'h0);
    add_vec(1, 1, 1, 5,  32'd10,         4'b0000, 1, 32'h0);
    add_vec(1, 1, 0, 5,  32'h0,          4'hF,    1, 32'h0);
    add_vec(1, 1, 1, 5,  32'h0000000A,   4'b1111, 1, 32'h0);
    add_vec(1, 1, 0, 5,  32'h0,          4'h0,    1, 32'h0000000A);
    add_vec(1, 1, 1, 31, 32'h11223344,   4'b1111, 1, 32'h0000000A);
    add_vec(1, 1, 1, 31, 32'hAABBCCDD,   4'b0101, 1, 32'h0000000A);
    add_vec(1, 1, 0, 31, 32'h0,          4'h0,    1, 32'h11BB33DD);
    add_vec(0, 1, 0, 5,  32'h0,          4'h0,    0, 32'h11BB33DD);
    add_vec(0, 1, 1, 5,  32'hFFFFFFFF,   4'hF,    0, 32'h11BB33DD);
    add_vec(1, 0, 1, 5,  32'hFFFFFFFF,   4'hF,    0, 32'h11BB33DD);
    add_vec(1, 1, 0, 5,  32'h0,          4'h0,    1, 32'h0000000A);
    add_vec(1, 1, 1, 0,  32'h12345678,   4'b1100, 1, 32'h0000000A);
    add_vec(1, 1, 0, 0,  32'h0,          4'h3,    1, 32'h12340000);
    add_vec(0, 0, 0, 0,  32'h0,          4'h0,    0, 32'h12340000);
    foreach (vecs[i])
      drive($sformatf("vec%0d", i), vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].addr,
            vecs[i].data, vecs[i].sel, vecs[i].eack, vecs[i].edata);

    // random phase against a behavioural model seeded with the table's end state
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_mem[0]  = 32'h12340000;
    model_mem[5]  = 32'h0000000A;
    model_mem[31] = 32'h11BB33DD;
    model_rd = 32'h12340000;
    for (int n = 0; n < 300; n++) begin
      c  = ($urandom_range(0, 7) != 0);
      s  = ($urandom_range(0, 7) != 0);
      w  = $urandom_range(0, 1);
      a  = AW'($urandom_range(0, DEPTH-1));
      d  = $urandom;
      sl = 4'($urandom_range(0, 15));
      if (c && s) begin
        if (w) begin
          for (int l = 0; l < 4; l++)
            if (sl[l]) model_mem[a][l*8 +: 8] = d[l*8 +: 8];
        end else begin
          model_rd = model_mem[a];
        end
      end
      drive($sformatf("rnd%0d", n), c, s, w, a, d, sl, c && s, model_rd);
    end

    // known nonzero read pending ack, then async reset between edges
    drive("pre.wr", 1, 1, 1, 7, 32'hDEADBEEF, 4'hF, 1, model_rd);
    drive("pre.rd", 1, 1, 0, 7, 32'h0, 4'h0, 1, 32'hDEADBEEF);
    m_i_cyc = 1'b1; m_i_stb = 1'b1; m_i_we = 1'b1; m_i_addr = 5'd9;
    m_i_data = 32'hCAFEF00D; m_i_sel = 4'hF;
    #2;
    m_rst = 1'b1;
    #1;
    chk("async.ack",  {{(DW-1){1'b0}}, m_o_ack}, '0);
    chk("async.data", m_o_read_data, '0);
    m_i_cyc = 1'b0; m_i_stb = 1'b0;
    @(posedge m_clk); #1;
    chk("inrst.ack", {{(DW-1){1'b0}}, m_o_ack}, '0);
    #2;
    m_rst = 1'b0;

    // every word reads zero; first post-reset request acked one cycle later
    for (int i = 0; i < DEPTH; i++)
      drive($sformatf("clr%0d", i), 1, 1, 0, AW'(i), 32'h0, 4'h0, 1, 32'h0);
    drive("end.idle", 0, 0, 0, 0, 32'h0, 4'h0, 0, 32'h0);

    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL sb.leftover actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/memory.md
Name: memory

Overview:
- Wishbone B4 pipelined-style slave RAM: 2^AWIDTH words, each DWIDTH bits wide, with byte-lane write enables.
- Serves as the data/instruction memory model behind a bus master in the processor subsystem.
- Single-cycle registered response: one access is accepted per clock and never stalls.

Parameters:
- DWIDTH, 32, data word width in bits. Must be divisible by 4; each select lane covers DWIDTH/4 bits.
- AWIDTH, 5, word-address width; depth is 2^AWIDTH words (32 by default).

Ports:
- m_clk  in  1  clock; all state updates on the rising edge.
- m_rst  in  1  reset, asynchronous, active-high.
- m_i_cyc  in  1  bus cycle active.
- m_i_stb  in  1  strobe; a request is valid when m_i_cyc & m_i_stb.
- m_i_we  in  1  1 = write, 0 = read.
- m_i_addr  in  AWIDTH  word address.
- m_i_data  in  DWIDTH  write data.
- m_i_sel  in  4  lane enables; bit i covers bits [i*DWIDTH/4 +: DWIDTH/4].
- m_o_read_data  out  DWIDTH  read data, registered.
- m_o_ack  out  1  response strobe, registered.
- m_o_stall  out  1  back-pressure, constant 0.

Behaviour:
- Reset (m_rst=1, asynchronous):
  - every memory word = 0
  - m_o_read_data = 0
  - m_o_ack = 0
  - m_o_stall = 0
- Request accepted on a rising edge when m_i_cyc & m_i_stb & !m_o_stall. Since stall is always 0, every valid edge accepts a request, so back-to-back requests are supported at one per clock.
- Ack timing:
  - m_o_ack = 1 in the cycle after each accepted request (latency 1).
  - m_o_ack = 0 in the cycle after any edge with no accepted request.
  - m_o_ack is also 0 after any edge where m_i_cyc=0; an abort drops the response.
- Write (m_i_we=1):
  - For each i with m_i_sel[i]=1, lane i of mem[m_i_addr] takes lane i of m_i_data. Unselected lanes are unchanged.
  - m_i_sel=0 writes nothing but is still acked.
  - m_o_read_data is unchanged by writes.
- Read (m_i_we=0):
  - m_o_read_data <= mem[m_i_addr], full word; m_i_sel is ignored.
  - Valid in the same cycle as m_o_ack. Holds its value until the next accepted read or reset.
- Read and write to the same address on consecutive cycles: the read returns the newly written data, because the write commits on the earlier edge.
- Address: all 2^AWIDTH values are valid; no out-of-range case and no wrap logic needed.
- Inputs are sampled only on clock edges; changes between edges have no effect.
- Reset asserted mid-transfer: any pending ack is cleared immediately and memory contents are zeroed. The first post-reset request is acked one cycle after acceptance.
- m_i_stb=1 with m_i_cyc=0: ignored, no memory change, no ack.

Decomposition:
- Shared bus package:
  - Wishbone constants: SEL_WIDTH=4, WE_READ=0, WE_WRITE=1.
  - Default DWIDTH/AWIDTH values.
- One natural sub-module, memory_array: 2^AWIDTH x DWIDTH storage with per-lane write enable, async clear and a registered read port.
- The top level holds the handshake and ack logic.

Test Plan:
- Reset then idle: m_rst pulsed with cyc=stb=0 -> m_o_ack=0, m_o_read_data=0x00000000, m_o_stall=0 on every cycle.
- Continuous read: cyc=stb=1, we=0, addr=0 -> m_o_ack=1 every cycle starting one cycle after the first accepted edge; data=0x00000000.
- Null-select write: we=1, addr=5, data=10, sel=4'b0000; then we=0, addr=5 -> ack=1 for both; read data=0x00000000 (no lanes written).
- Full write/read: we=1, addr=5, data=0x0000000A, sel=4'b1111; next cycle read addr=5 -> m_o_read_data=0x0000000A with m_o_ack=1.
- Partial write: addr=31 preloaded 0x11223344; write data=0xAABBCCDD, sel=4'b0101 -> read of addr 31 returns 0x11BB33DD.
- Abort and async reset: drop cyc with stb=1 -> no ack next cycle. Assert m_rst between edges after writes -> ack=0 immediately; every address reads 0x00000000 afterwards.
